// File: rtl/dff_mem_pkg.sv
// Shared types and header-field layout for the DFF memory command front-end.
package dff_mem_pkg;

  localparam int unsigned ADDR_BITS = 4;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned LEN_BITS  = 3;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned RAM_BYTES = 16;

  localparam int unsigned HDR_DIR_BIT  = 7;
  localparam int unsigned HDR_LEN_MSB  = 6;
  localparam int unsigned HDR_LEN_LSB  = 4;
  localparam int unsigned HDR_ADDR_MSB = 3;
  localparam int unsigned HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WDATA    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_CAPT  = 3'd3,
    ST_RD_RESP  = 3'd4
  } state_e;

  // Burst addresses wrap modulo the memory size.
  function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a);
    return ADDR_BITS'(a + 1'b1);
  endfunction

endpackage

// File: rtl/dff_mem_ctrl.sv
// Byte-stream command front-end sequencing single/burst writes and reads
// onto a 16-byte DFF memory with a registered read port.
module dff_mem_ctrl
  import dff_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [DATA_BITS-1:0] cmd_data,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic                 mem_wr_en,
  output logic                 mem_r_en,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 busy
);

  state_e               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  cnt_q;
  logic                 cmd_ready_q;
  logic [DATA_BITS-1:0] rsp_data_q;
  logic                 rsp_valid_q;
  logic [ADDR_BITS-1:0] mem_addr_q;
  logic [DATA_BITS-1:0] mem_wdata_q;
  logic                 mem_wr_en_q;
  logic                 mem_r_en_q;
  logic                 busy_q;

  logic                 cmd_hs;
  logic                 rsp_hs;
  logic                 hdr_write;
  logic [LEN_BITS-1:0]  hdr_len;
  logic [ADDR_BITS-1:0] hdr_addr;
  logic [ADDR_BITS-1:0] addr_d;
  logic [LEN_BITS-1:0]  cnt_d;
  logic                 last;

  assign cmd_hs    = cmd_valid && cmd_ready_q;
  assign rsp_hs    = rsp_valid_q && rsp_ready;
  assign hdr_write = cmd_data[HDR_DIR_BIT];
  assign hdr_len   = cmd_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_addr  = cmd_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
  assign addr_d    = addr_inc(addr_q);
  assign cnt_d     = LEN_BITS'(cnt_q - 1'b1);
  assign last      = (cnt_q == '0);

  // Strobes default low so each is a single-cycle pulse; cnt_q holds bytes remaining minus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      mem_r_en_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_wr_en_q <= 1'b0;
      mem_r_en_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= ena;
          if (cmd_hs) begin
            addr_q <= hdr_addr;
            cnt_q  <= hdr_len;
            busy_q <= 1'b1;
            if (hdr_write) begin
              state_q     <= ST_WDATA;
              cmd_ready_q <= 1'b1;
            end else begin
              // Read strobe goes out in the first RD_ISSUE cycle.
              state_q     <= ST_RD_ISSUE;
              cmd_ready_q <= 1'b0;
              mem_r_en_q  <= 1'b1;
              mem_addr_q  <= hdr_addr;
            end
          end
        end
        ST_WDATA: begin
          if (cmd_hs) begin
            mem_wr_en_q <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= cmd_data;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            if (last) begin
              state_q     <= ST_IDLE;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b0;
            end
          end
        end
        ST_RD_ISSUE: begin
          state_q <= ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          rsp_data_q  <= mem_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RD_RESP;
        end
        ST_RD_RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= 1'b0;
            if (last) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              addr_q     <= addr_d;
              cnt_q      <= cnt_d;
              mem_r_en_q <= 1'b1;
              mem_addr_q <= addr_d;
              state_q    <= ST_RD_ISSUE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_r_en  = mem_r_en_q;
  assign busy      = busy_q;

endmodule
